// File: rtl/ov7670_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_pkg
//  Description : Shared types and widths for the OV7670 capture path.
//                Holds the capture FSM state encoding, the frame buffer
//                address and pixel widths, and the luma-to-pixel helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ov7670_pkg;

    // Frame buffer write address width (covers 640*480 linear addresses)
    localparam int ADDR_W     = 19;
    // Stored grayscale pixel width
    localparam int PIX_W      = 4;
    // Pixel-in-line counter width (covers 640 plus headroom for long lines)
    localparam int LINE_CNT_W = 10;

    // Capture FSM state encoding
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        ACTIVE     = 2'd2
    } cap_state_t;

    // The stored pixel is the upper bits of the luma byte
    function automatic logic [PIX_W-1:0] luma_to_pixel(input logic [7:0] y);
        return y[7:8-PIX_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : cam_sync_edge
//  Description : Input stage for the OV7670 parallel bus. Registers VSYNC,
//                HREF and D[7:0] once, keeps a second copy of VSYNC and
//                HREF for edge detection, and presents VSYNC rise/fall and
//                HREF fall strobes aligned with the registered data.
//  Ports       : clk25      - camera PCLK
//                rst        - synchronous active-high reset
//                i_vsync    - raw VSYNC
//                i_href     - raw HREF
//                i_data     - raw D[7:0]
//                o_hr_q     - registered HREF
//                o_d_q      - registered data byte
//                o_vs_rise  - registered VSYNC went 0 -> 1
//                o_vs_fall  - registered VSYNC went 1 -> 0
//                o_hr_fall  - registered HREF went 1 -> 0
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_sync_edge (
    input  logic       clk25,
    input  logic       rst,
    input  logic       i_vsync,
    input  logic       i_href,
    input  logic [7:0] i_data,
    output logic       o_hr_q,
    output logic [7:0] o_d_q,
    output logic       o_vs_rise,
    output logic       o_vs_fall,
    output logic       o_hr_fall
);

    logic       r_vs_q;
    logic       r_vs_qq;
    logic       r_hr_q;
    logic       r_hr_qq;
    logic [7:0] r_d_q;

    always_ff @(posedge clk25) begin
        if (rst) begin
            r_vs_q  <= 1'b0;
            r_vs_qq <= 1'b0;
            r_hr_q  <= 1'b0;
            r_hr_qq <= 1'b0;
            r_d_q   <= 8'h00;
        end else begin
            r_vs_q  <= i_vsync;
            r_vs_qq <= r_vs_q;
            r_hr_q  <= i_href;
            r_hr_qq <= r_hr_q;
            r_d_q   <= i_data;
        end
    end

    // Strobes are asserted in the same cycle the new level appears on the
    // registered copy, so the consumer sees the edge together with d_q.
    assign o_hr_q    = r_hr_q;
    assign o_d_q     = r_d_q;
    assign o_vs_rise =  r_vs_q & ~r_vs_qq;
    assign o_vs_fall = ~r_vs_q &  r_vs_qq;
    assign o_hr_fall = ~r_hr_q &  r_hr_qq;

endmodule
`default_nettype wire

// File: rtl/ov7670_capture.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_capture
//  Description : Camera-side frame buffer writer. Samples the OV7670
//                YUV422 byte stream, keeps the luma byte of every pixel and
//                writes its upper nibble as a 4-bit grayscale pixel at
//                row-major linear addresses 0 .. hRez*vRez-1.
//  Ports       : clk25        - camera PCLK, sole clock
//                rst          - synchronous active-high reset
//                capture_en   - capture enable, honoured at frame boundaries
//                cam_vsync    - OV7670 VSYNC (high between frames)
//                cam_href     - OV7670 HREF (high during active bytes)
//                cam_data     - OV7670 D[7:0]
//                frame_we     - frame buffer write strobe
//                frame_addr   - frame buffer write address
//                frame_pixel  - frame buffer write data (Y[7:4])
//                frame_done   - one-cycle pulse at end of a captured frame
//                err_line     - sticky: a line had pixel count != hRez
//                err_overflow - sticky: frame exceeded hRez*vRez pixels
//  Revision    : 1.0 - initial release
// ============================================================================
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int hRez    = 640,
    parameter int vRez    = 480,
    parameter bit Y_FIRST = 1'b1
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              frame_we,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [PIX_W-1:0]  frame_pixel,
    output logic              frame_done,
    output logic              err_line,
    output logic              err_overflow
);

    localparam int                    FRAME_PIXELS   = hRez * vRez;
    localparam logic [ADDR_W-1:0]     c_FRAME_PIXELS = ADDR_W'(FRAME_PIXELS);
    localparam logic [LINE_CNT_W-1:0] c_HREZ         = LINE_CNT_W'(hRez);
    // Byte phase on which the luma byte of a pixel pair arrives
    localparam logic                  c_LUMA_PHASE   = ~Y_FIRST;

    // ------------------------------------------------------------------
    // Input registers and edge strobes
    // ------------------------------------------------------------------
    logic       w_hr_q;
    logic [7:0] w_d_q;
    logic       w_vs_rise;
    logic       w_vs_fall;
    logic       w_hr_fall;

    cam_sync_edge u_sync (
        .clk25     (clk25),
        .rst       (rst),
        .i_vsync   (cam_vsync),
        .i_href    (cam_href),
        .i_data    (cam_data),
        .o_hr_q    (w_hr_q),
        .o_d_q     (w_d_q),
        .o_vs_rise (w_vs_rise),
        .o_vs_fall (w_vs_fall),
        .o_hr_fall (w_hr_fall)
    );

    // Only the upper nibble of the byte becomes pixel data
    logic w_unused_d_lo;
    assign w_unused_d_lo = ^w_d_q[3:0];

    // ------------------------------------------------------------------
    // Capture control
    // ------------------------------------------------------------------
    cap_state_t            r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [LINE_CNT_W-1:0] r_line_cnt;
    logic                  r_phase;

    // A VSYNC rise while HREF is still high closes the line as well as the
    // frame, so the length check still runs on a truncated last line.
    logic w_line_end;
    logic w_luma;

    assign w_line_end = w_hr_fall | (w_vs_rise & w_hr_q);
    assign w_luma     = w_hr_q & (r_phase == c_LUMA_PHASE);

    always_ff @(posedge clk25) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_line_cnt   <= '0;
            r_phase      <= 1'b0;
            frame_we     <= 1'b0;
            frame_addr   <= '0;
            frame_pixel  <= '0;
            frame_done   <= 1'b0;
            err_line     <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            frame_we   <= 1'b0;
            frame_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    // Enable only takes effect at the start of a vsync gap
                    if (capture_en && w_vs_rise) begin
                        r_state <= WAIT_START;
                    end
                end

                WAIT_START: begin
                    if (w_vs_fall) begin
                        r_state      <= ACTIVE;
                        r_addr       <= '0;
                        r_line_cnt   <= '0;
                        r_phase      <= 1'b0;
                        err_line     <= 1'b0;
                        err_overflow <= 1'b0;
                    end
                end

                ACTIVE: begin
                    if (w_line_end) begin
                        if (r_line_cnt != c_HREZ) begin
                            err_line <= 1'b1;
                        end
                        r_line_cnt <= '0;
                        r_phase    <= 1'b0;
                    end else if (w_hr_q) begin
                        r_phase <= ~r_phase;
                        if (w_luma) begin
                            // Count every luma byte, written or not, so a
                            // full-length line past the buffer end is not
                            // also reported as a bad line.
                            if (r_line_cnt != '1) begin
                                r_line_cnt <= r_line_cnt + LINE_CNT_W'(1);
                            end
                            if (r_addr < c_FRAME_PIXELS) begin
                                frame_we    <= 1'b1;
                                frame_addr  <= r_addr;
                                frame_pixel <= luma_to_pixel(w_d_q);
                                r_addr      <= r_addr + ADDR_W'(1);
                            end else begin
                                err_overflow <= 1'b1;
                            end
                        end
                    end

                    // Address is never realigned per line: short or long
                    // lines simply shift the rest of the frame.
                    if (w_vs_rise) begin
                        frame_done <= 1'b1;
                        r_state    <= capture_en ? WAIT_START : IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ov7670_capture
//  Description : Self-checking bench for ov7670_capture. Two instances with
//                hRez=8, vRez=4 share one byte stream: one YUYV build
//                (Y_FIRST=1) and one UYVY build (Y_FIRST=0). Expected
//                writes are queued as bytes are driven and a monitor pops
//                them as frame_we appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_capture;

    localparam int c_H   = 8;
    localparam int c_V   = 4;
    localparam int c_PIX = c_H * c_V;

    typedef struct packed {
        logic [18:0] addr;
        logic [3:0]  pix;
    } wr_t;

    logic        clk25;
    logic        rst;
    logic        capture_en;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;

    logic        we_y, done_y, el_y, eo_y;
    logic [18:0] addr_y;
    logic [3:0]  pix_y;
    logic        we_u, done_u, el_u, eo_u;
    logic [18:0] addr_u;
    logic [3:0]  pix_u;

    ov7670_capture #(.hRez(c_H), .vRez(c_V), .Y_FIRST(1'b1)) dut_y (
        .clk25        (clk25),
        .rst          (rst),
        .capture_en   (capture_en),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data     (cam_data),
        .frame_we     (we_y),
        .frame_addr   (addr_y),
        .frame_pixel  (pix_y),
        .frame_done   (done_y),
        .err_line     (el_y),
        .err_overflow (eo_y)
    );

    ov7670_capture #(.hRez(c_H), .vRez(c_V), .Y_FIRST(1'b0)) dut_u (
        .clk25        (clk25),
        .rst          (rst),
        .capture_en   (capture_en),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data     (cam_data),
        .frame_we     (we_u),
        .frame_addr   (addr_u),
        .frame_pixel  (pix_u),
        .frame_done   (done_u),
        .err_line     (el_u),
        .err_overflow (eo_u)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    wr_t q_y[$];
    wr_t q_u[$];
    int  checks     = 0;
    int  failures   = 0;
    int  wr_cnt_y   = 0;
    int  wr_cnt_u   = 0;
    int  done_cnt_y = 0;
    int  done_cnt_u = 0;
    int  exp_a_y    = 0;
    int  exp_a_u    = 0;
    bit  expect_on  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected write per observed frame_we
    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk25);
            if (done_y) done_cnt_y++;
            if (done_u) done_cnt_u++;
            if (we_y) begin
                wr_cnt_y++;
                if (q_y.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_y_unexpected: got write addr %0d pix %0h expected no write", addr_y, pix_y);
                end else begin
                    e = q_y.pop_front();
                    chk("wr_y_addr", 32'(addr_y), 32'(e.addr));
                    chk("wr_y_pix",  32'(pix_y),  32'(e.pix));
                end
            end
            if (we_u) begin
                wr_cnt_u++;
                if (q_u.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_u_unexpected: got write addr %0d pix %0h expected no write", addr_u, pix_u);
                end else begin
                    e = q_u.pop_front();
                    chk("wr_u_addr", 32'(addr_u), 32'(e.addr));
                    chk("wr_u_pix",  32'(pix_u),  32'(e.pix));
                end
            end
        end
    endtask

    // mode 0: even bytes 0x00,0x10.. (luma ramp for YUYV), odd bytes 0x80
    // mode 1: UYVY with U/V=0xF0 on even bytes, Y=0x30 on odd bytes
    function automatic logic [7:0] byte_val(input int mode, input int idx);
        if (mode == 0) return (idx % 2 == 0) ? 8'(((idx / 2) % 16) << 4) : 8'h80;
        return (idx % 2 == 0) ? 8'hF0 : 8'h30;
    endfunction

    task automatic drive_byte(input logic [7:0] b, input int idx, input bit push);
        wr_t e;
        @(negedge clk25);
        cam_href = 1'b1;
        cam_data = b;
        if (push && expect_on) begin
            e.pix = b[7:4];
            if (idx % 2 == 0) begin
                if (exp_a_y < c_PIX) begin
                    e.addr = 19'(exp_a_y);
                    q_y.push_back(e);
                    exp_a_y++;
                end
            end else begin
                if (exp_a_u < c_PIX) begin
                    e.addr = 19'(exp_a_u);
                    q_u.push_back(e);
                    exp_a_u++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk25);
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (n - 1) @(negedge clk25);
    endtask

    task automatic send_line(input int nbytes, input int mode);
        for (int i = 0; i < nbytes; i++) drive_byte(byte_val(mode, i), i, 1'b1);
        idle(4);
    endtask

    task automatic vs_rise();
        @(negedge clk25);
        cam_vsync = 1'b1;
        repeat (6) @(negedge clk25);
    endtask

    task automatic vs_fall(input bit start);
        @(negedge clk25);
        cam_vsync = 1'b0;
        expect_on = start;
        if (start) begin
            exp_a_y = 0;
            exp_a_u = 0;
        end
        repeat (4) @(negedge clk25);
    endtask

    task automatic check_frame(input string name, input int exp_w, input int exp_done,
                               input logic exp_el, input logic exp_eo);
        $display("-- %s", name);
        chk("writes_y", 32'(wr_cnt_y), 32'(exp_w));
        chk("writes_u", 32'(wr_cnt_u), 32'(exp_w));
        chk("done_y", 32'(done_cnt_y), 32'(exp_done));
        chk("done_u", 32'(done_cnt_u), 32'(exp_done));
        chk("err_line_y", 32'(el_y), 32'(exp_el));
        chk("err_line_u", 32'(el_u), 32'(exp_el));
        chk("err_ovf_y", 32'(eo_y), 32'(exp_eo));
        chk("err_ovf_u", 32'(eo_u), 32'(exp_eo));
        chk("pending_y", 32'(q_y.size()), 32'd0);
        chk("pending_u", 32'(q_u.size()), 32'd0);
        wr_cnt_y   = 0;
        wr_cnt_u   = 0;
        done_cnt_y = 0;
        done_cnt_u = 0;
    endtask

    task automatic check_zero(input string name);
        $display("-- %s", name);
        chk("rst_we_y",   32'(we_y),   32'd0);
        chk("rst_addr_y", 32'(addr_y), 32'd0);
        chk("rst_pix_y",  32'(pix_y),  32'd0);
        chk("rst_done_y", 32'(done_y), 32'd0);
        chk("rst_el_y",   32'(el_y),   32'd0);
        chk("rst_eo_y",   32'(eo_y),   32'd0);
        chk("rst_we_u",   32'(we_u),   32'd0);
        chk("rst_addr_u", 32'(addr_u), 32'd0);
        chk("rst_pix_u",  32'(pix_u),  32'd0);
        chk("rst_done_u", 32'(done_u), 32'd0);
        chk("rst_el_u",   32'(el_u),   32'd0);
        chk("rst_eo_u",   32'(eo_u),   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        capture_en = 1'b0;
        cam_vsync  = 1'b0;
        cam_href   = 1'b0;
        cam_data   = 8'h00;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk25);
        check_zero("reset");
        rst = 1'b0;
        capture_en = 1'b1;
        idle(3);

        // 1: YUYV ramp, pixels 0..7 per line (UYVY build sees chroma 0x8)
        vs_rise();
        vs_fall(1'b1);
        for (int l = 0; l < 4; l++) send_line(16, 0);
        vs_rise();
        check_frame("t1_ramp", 32, 1, 1'b0, 1'b0);

        // 2: UYVY stream, Y=0x30 -> 3 on UYVY build, 0xF on YUYV build
        vs_fall(1'b1);
        for (int l = 0; l < 4; l++) send_line(16, 1);
        vs_rise();
        check_frame("t2_uyvy", 32, 1, 1'b0, 1'b0);

        // 3: second line is 14 bytes -> 31 writes, err_line set
        vs_fall(1'b1);
        send_line(16, 0);
        send_line(14, 0);
        send_line(16, 0);
        send_line(16, 0);
        vs_rise();
        check_frame("t3_short_line", 31, 1, 1'b1, 1'b0);
        vs_fall(1'b1);
        chk("t3_el_clear_y", 32'(el_y), 32'd0);
        chk("t3_el_clear_u", 32'(el_u), 32'd0);

        // 4: five full lines -> 32 writes then overflow
        for (int l = 0; l < 5; l++) send_line(16, 0);
        vs_rise();
        check_frame("t4_overflow", 32, 1, 1'b0, 1'b1);

        // 5: capture_en dropped mid-frame; frame completes, next one ignored
        vs_fall(1'b1);
        send_line(16, 0);
        @(negedge clk25);
        capture_en = 1'b0;
        for (int l = 0; l < 3; l++) send_line(16, 0);
        vs_rise();
        check_frame("t5_frame", 32, 1, 1'b0, 1'b0);
        vs_fall(1'b0);
        for (int l = 0; l < 4; l++) send_line(16, 0);
        vs_rise();
        check_frame("t5_idle", 0, 0, 1'b0, 1'b0);
        vs_fall(1'b0);

        // 6: reset mid-line after 5 writes per build
        capture_en = 1'b1;
        vs_rise();
        vs_fall(1'b1);
        for (int i = 0; i < 10; i++) drive_byte(byte_val(0, i), i, 1'b1);
        drive_byte(byte_val(0, 10), 10, 1'b0);
        @(negedge clk25);
        rst = 1'b1;
        @(negedge clk25);
        check_zero("t6_after_rst");
        rst = 1'b0;
        expect_on = 1'b0;
        check_frame("t6_partial", 5, 0, 1'b0, 1'b0);
        for (int i = 11; i < 16; i++) drive_byte(byte_val(0, i), i, 1'b0);
        idle(4);
        send_line(16, 0);
        vs_rise();
        check_frame("t6_no_restart", 0, 0, 1'b0, 1'b0);
        vs_fall(1'b1);
        send_line(16, 0);
        vs_rise();
        check_frame("t6_restart", 8, 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
